// File: rtl/wave_dac_spi_if.sv
// wave_dac_spi_if: sample handshake between wave_gen and wave_dac_spi.
// master drives sample/valid, slave answers with ready.
interface wave_dac_spi_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] sample;
  logic             valid;
  logic             ready;

  modport master (
    output sample,
    output valid,
    input  ready
  );

  modport slave (
    input  sample,
    input  valid,
    output ready
  );
endinterface

// File: rtl/wave_dac_spi.sv
// wave_dac_spi: serializes signed samples to an SPI DAC (mode 0, MSB first).
// Define WAVE_DAC_LDAC_EN to add the o_ldac_n load strobe after each frame.
module wave_dac_spi #(
  parameter int                  WIDTH    = 24,
  parameter int                  CMD_BITS = 8,
  parameter logic [CMD_BITS-1:0] CMD_WORD = 8'h30,
  parameter int                  CLK_DIV  = 4,
  parameter int                  CS_IDLE  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  wave_dac_spi_if.slave bus,
  output logic          o_sclk,
  output logic          o_cs_n,
  output logic          o_mosi,
  output logic          o_busy,
`ifdef WAVE_DAC_LDAC_EN
  output logic          o_ldac_n,
`endif
  output logic          o_frame_done
);

  localparam int N = CMD_BITS + WIDTH;
`ifdef WAVE_DAC_LDAC_EN
  localparam int HOLD_LEN = CS_IDLE + CLK_DIV;
`else
  localparam int HOLD_LEN = CS_IDLE;
`endif
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(N);
  localparam int HC_W  = $clog2(HOLD_LEN + 1);

  localparam logic [WIDTH-1:0] SIGN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     sh, sh_n;
  logic [DIV_W-1:0] div, div_n;
  logic [BIT_W-1:0] bcnt, bcnt_n;
  logic [HC_W-1:0]  hcnt, hcnt_n;
  logic             sclk, sclk_n;
  logic             div_end;
  logic             active;

  assign div_end = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      sh    <= '0;
      div   <= '0;
      bcnt  <= '0;
      hcnt  <= '0;
      sclk  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      div   <= div_n;
      bcnt  <= bcnt_n;
      hcnt  <= hcnt_n;
      sclk  <= sclk_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    div_n   = div;
    bcnt_n  = bcnt;
    hcnt_n  = hcnt;
    sclk_n  = sclk;
    unique case (state)
      IDLE: begin
        if (bus.valid) begin
          state_n = SETUP;
          sh_n    = {CMD_WORD, bus.sample ^ SIGN};
          div_n   = '0;
          bcnt_n  = BIT_W'(N - 1);
          hcnt_n  = '0;
          sclk_n  = 1'b0;
        end
      end
      SETUP: begin
        if (div_end) begin
          div_n   = '0;
          sclk_n  = 1'b1;
          state_n = SHIFT;
        end else begin
          div_n = div + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_end) begin
          div_n = div + 1'b1;
        end else begin
          div_n = '0;
          // falling edge advances data; end of low half decides next bit
          if (sclk) begin
            sclk_n = 1'b0;
            sh_n   = {sh[N-2:0], 1'b0};
          end else if (bcnt == '0) begin
            state_n = HOLD;
            hcnt_n  = '0;
          end else begin
            bcnt_n = bcnt - 1'b1;
            sclk_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hcnt == HC_W'(HOLD_LEN - 1)) begin
          state_n = IDLE;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign active       = (state == SETUP) || (state == SHIFT);
  assign o_sclk       = sclk;
  assign o_cs_n       = !active;
  assign o_mosi       = active && sh[N-1];
  assign o_busy       = (state != IDLE);
  assign bus.ready    = (state == IDLE);
  assign o_frame_done = (state == HOLD) && (hcnt == '0);
`ifdef WAVE_DAC_LDAC_EN
  assign o_ldac_n = !((state == HOLD) && (hcnt >= HC_W'(CS_IDLE)));
`endif

endmodule

// File: tb/tb_wave_dac_spi.sv
// tb_wave_dac_spi: directed bench with a timeline model of each frame.
// Instance a uses defaults, instance b uses CLK_DIV=1, CS_IDLE=1.
module tb_wave_dac_spi;

`ifdef WAVE_DAC_LDAC_EN
  localparam int LX = 1;
`else
  localparam int LX = 0;
`endif
  localparam int HA = 2 + 4 * LX;
  localparam int PA = 1 + 4 * 65 + HA;
  localparam int HB = 1 + 1 * LX;
  localparam int PB = 1 + 1 * 65 + HB;
  localparam int PA_LIT = LX ? 267 : 263;
  localparam int PB_LIT = LX ? 68 : 67;

  typedef struct packed {
    logic ready;
    logic busy;
    logic cs_n;
    logic sclk;
    logic mosi;
    logic done;
    logic ldac_n;
    logic mosi_dc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  wave_dac_spi_if #(.WIDTH(24)) ia ();
  wave_dac_spi_if #(.WIDTH(24)) ib ();

  logic sclk_a, cs_a, mosi_a, busy_a, done_a, ldac_a;
  logic sclk_b, cs_b, mosi_b, busy_b, done_b, ldac_b;

  wave_dac_spi dut_a (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (ia),
    .o_sclk      (sclk_a),
    .o_cs_n      (cs_a),
    .o_mosi      (mosi_a),
    .o_busy      (busy_a),
`ifdef WAVE_DAC_LDAC_EN
    .o_ldac_n    (ldac_a),
`endif
    .o_frame_done(done_a)
  );

  wave_dac_spi #(.CLK_DIV(1), .CS_IDLE(1)) dut_b (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (ib),
    .o_sclk      (sclk_b),
    .o_cs_n      (cs_b),
    .o_mosi      (mosi_b),
    .o_busy      (busy_b),
`ifdef WAVE_DAC_LDAC_EN
    .o_ldac_n    (ldac_b),
`endif
    .o_frame_done(done_b)
  );

`ifndef WAVE_DAC_LDAC_EN
  assign ldac_a = 1'b1;
  assign ldac_b = 1'b1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ta = 0, tbm = 0;
  logic [31:0] fa = '0, fb = '0;
  int acc_a = -1, acc_b = -1;
  logic per_a = 1'b0, per_b = 1'b0;
  logic [31:0] cap_a = '0, cap_b = '0;
  int rise_a = 0, rise_b = 0;
  logic sp_a = 1'b0, sp_b = 1'b0;
  int dcnt_a = 0, dcnt_b = 0;
  logic got;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic cs_pa = 1'b1;
  int cs_rise = 0;
  int lrun = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Expected outputs t cycles after the accept cycle (t=0: idle)
  function automatic exp_t model(int t, logic [31:0] f,
                                 int d, int cs, int hl);
    exp_t e;
    int   u, k;
    int   ns;
    ns = 64 * d;
    e = '{ready:1'b1, busy:1'b0, cs_n:1'b1, sclk:1'b0,
          mosi:1'b0, done:1'b0, ldac_n:1'b1, mosi_dc:1'b0};
    if (t == 0) return e;
    e.ready = 1'b0;
    e.busy  = 1'b1;
    if (t <= d) begin
      e.cs_n = 1'b0;
      e.mosi = f[31];
    end else if (t <= d + ns) begin
      u = t - d - 1;
      k = u / (2 * d);
      e.cs_n = 1'b0;
      if ((u % (2 * d)) < d) begin
        e.sclk = 1'b1;
        e.mosi = f[31-k];
      end else if (k < 31) begin
        e.mosi = f[30-k];
      end else begin
        e.mosi_dc = 1'b1;
      end
    end else begin
      u = t - d - ns - 1;
      e.done   = (u == 0);
      e.ldac_n = !(hl > cs && u >= cs);
    end
    return e;
  endfunction

  task automatic cmp(string nm, int t, logic [31:0] f, int d,
                     int cs, int hl, logic rdy, logic bsy,
                     logic csn, logic sck, logic mo, logic dn,
                     logic ld);
    exp_t e;
    logic [6:0] act, want;
    e = model(t, f, d, cs, hl);
    act  = {rdy, bsy, csn, sck, mo, dn, ld};
    want = {e.ready, e.busy, e.cs_n, e.sclk, e.mosi, e.done, e.ldac_n};
    if (e.mosi_dc) act[2] = want[2];
    chk($sformatf("%s outputs t=%0d", nm, t), {25'd0, act}, {25'd0, want});
  endtask

  task automatic adv(inout int t, inout logic [31:0] f,
                     input logic v, input logic [23:0] s, input int p);
    if (rst) t = 0;
    else if (t == 0) begin
      if (v) begin
        t = 1;
        f = {8'h30, s ^ 24'h800000};
      end
    end else if (t == p - 1) t = 0;
    else t++;
  endtask

  task automatic mon(string nm, int off, logic bsy, logic sck,
                     logic mo, logic dn, int acc,
                     inout logic [31:0] cap, inout int rise,
                     inout logic sp, inout int dcnt, output logic g);
    if (!bsy) begin
      cap  = '0;
      rise = 0;
    end else if (sck && !sp) begin
      cap = {cap[30:0], mo};
      rise++;
    end
    g = 1'b0;
    if (dn) begin
      chk({nm, " done offset"}, cyc - acc, off);
      chk({nm, " rising edges"}, rise, 32);
      dcnt++;
      g = 1'b1;
    end
    sp = sck;
  endtask

  task automatic tick();
    if (!rst && ia.valid && ia.ready) begin
      if (per_a && acc_a >= 0) chk("a accept period", cyc - acc_a, PA_LIT);
      acc_a = cyc;
    end
    if (!rst && ib.valid && ib.ready) begin
      if (per_b && acc_b >= 0) chk("b accept period", cyc - acc_b, PB_LIT);
      acc_b = cyc;
    end
    adv(ta, fa, ia.valid, ia.sample, PA);
    adv(tbm, fb, ib.valid, ib.sample, PB);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    cmp("a", ta, fa, 4, 2, HA, ia.ready, busy_a, cs_a, sclk_a,
        mosi_a, done_a, ldac_a);
    cmp("b", tbm, fb, 1, 1, HB, ib.ready, busy_b, cs_b, sclk_b,
        mosi_b, done_b, ldac_b);
    mon("a", 261, busy_a, sclk_a, mosi_a, done_a, acc_a,
        cap_a, rise_a, sp_a, dcnt_a, got);
    if (got && qa.size() > 0) chk("a frame bits", cap_a, qa.pop_front());
    mon("b", 66, busy_b, sclk_b, mosi_b, done_b, acc_b,
        cap_b, rise_b, sp_b, dcnt_b, got);
    if (got && qb.size() > 0) chk("b frame bits", cap_b, qb.pop_front());
    if (cs_a && !cs_pa) cs_rise = cyc;
    if (!ldac_a) begin
      if (lrun == 0) chk("ldac start after cs rise", cyc - cs_rise, 2);
      lrun++;
    end else if (lrun > 0) begin
      chk("ldac low width", lrun, 4);
      lrun = 0;
    end
    cs_pa = cs_a;
  endtask

  task automatic wait_done(input logic sel_b);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (sel_b ? done_b : done_a) return;
    end
    chk("done timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      if (ia.ready && ib.ready) return;
      tick();
    end
    chk("idle timeout", 0, 1);
  endtask

  task automatic send_a(logic [23:0] s, logic [31:0] bits);
    qa.push_back(bits);
    ia.sample = s;
    ia.valid  = 1'b1;
    tick();
    ia.valid  = 1'b0;
    wait_done(1'b0);
    wait_idle();
  endtask

  initial begin
    rst       = 1'b1;
    ia.valid  = 1'b0;
    ia.sample = '0;
    ib.valid  = 1'b0;
    ib.sample = '0;
    repeat (3) tick();
    chk("reset a", {25'd0, ia.ready, busy_a, cs_a, sclk_a, mosi_a,
        done_a, ldac_a}, 32'h51);
    chk("reset b", {25'd0, ib.ready, busy_b, cs_b, sclk_b, mosi_b,
        done_b, ldac_b}, 32'h51);
    rst = 1'b0;
    tick();

    send_a(24'h000000, 32'h30800000);
    send_a(24'h7FFFFF, 32'h30FFFFFF);
    send_a(24'h800000, 32'h30000000);
    send_a(24'h123456, 32'h30923456);
    send_a(24'hFFFFFF, 32'h307FFFFF);

    // valid held high with a new sample every cycle
    per_a    = 1'b1;
    ia.valid = 1'b1;
    for (int i = 0; i < 3 * PA; i++) begin
      ia.sample = 24'(i * 24'h010203 + 5);
      tick();
    end
    ia.valid = 1'b0;
    per_a    = 1'b0;
    wait_idle();

    // reset in the middle of a frame
    ia.sample = 24'h55AA33;
    ia.valid  = 1'b1;
    tick();
    ia.valid  = 1'b0;
    for (int i = 0; i < 200 && rise_a < 10; i++) tick();
    chk("a rise before abort", rise_a, 10);
    rst = 1'b1;
    tick();
    chk("abort state", {28'd0, cs_a, sclk_a, ia.ready, done_a}, 32'hA);
    rst = 1'b0;
    tick();
    send_a(24'hABCDEF, 32'h302BCDEF);
    chk("a frames completed", dcnt_a, 9);

    // fast divider instance
    qb.push_back(32'h30923456);
    ib.sample = 24'h123456;
    ib.valid  = 1'b1;
    tick();
    ib.valid  = 1'b0;
    wait_done(1'b1);
    wait_idle();
    per_b    = 1'b1;
    ib.valid = 1'b1;
    for (int i = 0; i < 2 * PB; i++) begin
      ib.sample = 24'(24'h800001 + i * 24'h000111);
      tick();
    end
    ib.valid = 1'b0;
    per_b    = 1'b0;
    wait_idle();
    chk("b frames completed", dcnt_b, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
